mdu_ctrl: RTL



---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_arith.sv | 78 +++++++
 rtl/mdu_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and the default latencies that the Conflict unit's stall timing assumes.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE = 3'd0,
        MULT     = 3'd1,
        MULTU    = 3'd2,
        DIV      = 3'd3,
        DIVU     = 3'd4,
        MTHI     = 3'd5,
        MTLO     = 3'd6
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu, including the
// divide-by-zero (keep current HI/LO) and signed-overflow special cases.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        div_n;
    logic [31:0]        div_d;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic [31:0]        sq;
    logic [31:0]        sr;
    logic               div_zero;
    logic               div_ovf;

    always_comb begin
        prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u   = {32'd0, a} * {32'd0, b};
        mag_a    = a[31] ? (~a + 32'd1) : a;
        mag_b    = b[31] ? (~b + 32'd1) : b;
        div_zero = (b == 32'd0);
        div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

        // Signed divide works on magnitudes; the divisor is forced non-zero so
        // the quotient logic never sees x/0, the result is discarded anyway.
        div_n = (mdu_op_e'(op) == DIV) ? mag_a : a;
        div_d = (mdu_op_e'(op) == DIV) ? mag_b : b;
        if (div_zero) begin
            div_d = 32'd1;
        end
        uq = div_n / div_d;
        ur = div_n % div_d;
        sq = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
        sr = a[31] ? (~ur + 32'd1) : ur;

        res_hi = cur_hi;
        res_lo = cur_lo;
        case (mdu_op_e'(op))
            MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            DIV: begin
                if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else if (!div_zero) begin
                    res_hi = sr;
                    res_lo = sq;
                end
            end
            DIVU: begin
                if (!div_zero) begin
                    res_hi = ur;
                    res_lo = uq;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Execute-stage MDU sequencer: owns HI/LO, emulates the fixed mult/div latency
// the Conflict unit stalls on, and drops any op flushed by a CP0 request.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             accept;

    mdu_arith u_arith (
        .op     (op),
        .a      (rs_data),
        .b      (rt_data),
        .cur_hi (hi_q),
        .cur_lo (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        accept    = start && !Req && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (mdu_op_e'(op))
                        MULT, MULTU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = MULT_LAT;
                            state_d   = BUSY;
                        end
                        DIV, DIVU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = DIV_LAT;
                            state_d   = BUSY;
                        end
                        MTHI:    hi_d = rs_data;
                        MTLO:    lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // Req is ignored here: the op belongs to an already-committed instruction.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // The Conflict unit stalls issue while busy, so a start here is a protocol error.
    start_while_busy_a : assert property (@(posedge clk) disable iff (reset)
        !(start && state_q == BUSY));

endmodule
